// File: rtl/b4to1_rr_multiplexer_pkg.sv
// Shared definitions for the 4-to-1 round-robin multiplexer.
// Contents: output-register state encodings and the channel count.
package b4to1_rr_multiplexer_pkg;

  localparam logic [0:0]  S_EMPTY = 1'b0;
  localparam logic [0:0]  S_FULL  = 1'b1;
  localparam int unsigned N_CH    = 4;

endpackage

// File: rtl/b4to1_rr_multiplexer_if.sv
// Handshake bundle for b4to1_rr_multiplexer.
// Signals: x3_x0_valid/x3_x0_data/x3_x0_ready form the four input channels,
// with channel i on x3_x0_data[i*W +: W].
// z_valid/z_data/z_ready form the output channel.
// b1_b0 is the source-channel tag of the word on z_data.
// Modports: slave is the multiplexer side; master is the producer/consumer side.
interface b4to1_rr_multiplexer_if #(
  parameter int W = 8
);

  logic [3:0]     x3_x0_valid;
  logic [4*W-1:0] x3_x0_data;
  logic [3:0]     x3_x0_ready;
  logic           z_valid;
  logic [W-1:0]   z_data;
  logic [1:0]     b1_b0;
  logic           z_ready;

  modport slave (
    input  x3_x0_valid, x3_x0_data, z_ready,
    output x3_x0_ready, z_valid, z_data, b1_b0
  );

  modport master (
    output x3_x0_valid, x3_x0_data, z_ready,
    input  x3_x0_ready, z_valid, z_data, b1_b0
  );

endinterface

// File: rtl/b4to1_rr_multiplexer_rr4_arbiter.sv
// rr4_arbiter: purely combinational round-robin priority search.
// Ports: req[3:0] request flags, ptr[1:0] highest-priority channel,
//        gnt[3:0] one-hot (or zero) grant to the first requester found
//        searching ptr, ptr+1, ptr+2, ptr+3 modulo 4.
module rr4_arbiter
  import b4to1_rr_multiplexer_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      // 2-bit addition gives the modulo-4 wrap for free
      idx = ptr + 2'(off);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/b4to1_rr_multiplexer.sv
// b4to1_rr_multiplexer: four valid/ready input channels merged by round-robin
// arbitration into a single one-entry registered output with a source tag.
// Ports: clock            rising-edge clock
//        reset            asynchronous, active-high
//        bus (slave)      input channels, output channel and b1_b0 tag
// A new word may be loaded on the same edge the held word is consumed, so a
// continuously ready consumer sees one word per cycle.
module b4to1_rr_multiplexer
  import b4to1_rr_multiplexer_pkg::*;
#(
  parameter int W = 8
)(
  input  logic                    clock,
  input  logic                    reset,
  b4to1_rr_multiplexer_if.slave   bus
);

  logic [0:0]   state_q, state_d;
  logic [W-1:0] data_q,  data_d;
  logic [1:0]   tag_q,   tag_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;

  logic         slot_free;
  logic         in_xfer;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [1:0]   gidx;
  logic [W-1:0] sel_data;

  assign slot_free = (state_q == S_EMPTY) || bus.z_ready;

  // Masking requests with reset keeps every ready low while reset is held.
  assign req = reset ? '0 : bus.x3_x0_valid;

  rr4_arbiter u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign bus.x3_x0_ready = slot_free ? gnt : '0;
  // A grant only exists for a valid channel, so any ready bit is a transfer.
  assign in_xfer = |bus.x3_x0_ready;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt[i]) gidx = 2'(i);
    end
  end

  assign sel_data = bus.x3_x0_data[int'(gidx)*W +: W];

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (in_xfer) begin
      state_d  = S_FULL;
      data_d   = sel_data;
      tag_d    = gidx;
      rr_ptr_d = gidx + 2'd1;
    end else if (state_q == S_FULL && bus.z_ready) begin
      state_d  = S_EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      data_q   <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.z_valid = (state_q == S_FULL);
  assign bus.z_data  = data_q;
  assign bus.b1_b0   = tag_q;

endmodule

// File: tb/tb_b4to1_rr_multiplexer.sv
// Self-checking bench for b4to1_rr_multiplexer (W=8): directed scenarios
// followed by a randomized run against a behavioural reference.
module tb_b4to1_rr_multiplexer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  b4to1_rr_multiplexer_if #(.W(8)) bus ();

  b4to1_rr_multiplexer #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    bus.x3_x0_data[ch*8 +: 8] = v;
  endtask

  // Rotate-and-scan reference for the round-robin grant.
  function automatic logic [3:0] rr_model(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    dbl = {r, r} >> p;
    for (int k = 0; k < 4; k++) begin
      if (dbl[k]) return 4'b0001 << ((int'(p) + k) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return 0;
  endfunction

  initial begin
    logic        mfull;
    logic [7:0]  mdata;
    logic [1:0]  mtag;
    logic [1:0]  mptr;
    logic [3:0]  mg;
    logic [3:0]  dg;
    int          seq     [4];
    int          exp_seq [4];
    int          waitc   [4];
    int          oc;

    bus.x3_x0_valid = 4'b1111;
    bus.x3_x0_data  = '0;
    bus.z_ready     = 1'b0;

    // Reset state, with every channel requesting
    #12;
    check("rst_zvalid", 32'(bus.z_valid), 32'd0);
    check("rst_zdata",  32'(bus.z_data), 32'h00);
    check("rst_tag",    32'(bus.b1_b0), 32'd0);
    check("rst_ready",  32'(bus.x3_x0_ready), 32'b0000);
    check("rst_ptr",    32'(dut.rr_ptr_q), 32'd0);

    // Single word from channel 2
    tick();
    reset = 1'b0;
    bus.x3_x0_valid = 4'b0100;
    set_data(2, 8'h5A);
    bus.z_ready = 1'b1;
    #1;
    check("s1_ready", 32'(bus.x3_x0_ready), 32'b0100);
    tick();
    bus.x3_x0_valid = 4'b0000;
    check("s1_zvalid", 32'(bus.z_valid), 32'd1);
    check("s1_zdata",  32'(bus.z_data), 32'h5A);
    check("s1_tag",    32'(bus.b1_b0), 32'd2);
    check("s1_ptr",    32'(dut.rr_ptr_q), 32'd3);
    tick();
    check("drain_zvalid", 32'(bus.z_valid), 32'd0);
    check("drain_zdata",  32'(bus.z_data), 32'h5A);
    check("drain_tag",    32'(bus.b1_b0), 32'd2);
    check("drain_ptr",    32'(dut.rr_ptr_q), 32'd3);

    // Pointer wrap from 3 to 0
    bus.x3_x0_valid = 4'b1001;
    set_data(3, 8'h33);
    set_data(0, 8'h11);
    #1;
    check("wrap_ready3", 32'(bus.x3_x0_ready), 32'b1000);
    tick();
    check("wrap_zdata3", 32'(bus.z_data), 32'h33);
    check("wrap_tag3",   32'(bus.b1_b0), 32'd3);
    check("wrap_ptr0",   32'(dut.rr_ptr_q), 32'd0);
    #1;
    check("wrap_ready0", 32'(bus.x3_x0_ready), 32'b0001);
    tick();
    bus.x3_x0_valid = 4'b0000;
    check("wrap_zdata0", 32'(bus.z_data), 32'h11);
    check("wrap_tag0",   32'(bus.b1_b0), 32'd0);
    check("wrap_ptr1",   32'(dut.rr_ptr_q), 32'd1);

    // All channels busy: tag sequence 0,1,2,3,0,1,2,3 without bubbles
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check("rr_ptr_after_rst", 32'(dut.rr_ptr_q), 32'd0);
    bus.x3_x0_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_zvalid", 32'(bus.z_valid), 32'd1);
      check("rr_tag",    32'(bus.b1_b0), 32'(k % 4));
      check("rr_zdata",  32'(bus.z_data), 32'(8'hA0 + k % 4));
    end

    // Back-pressure: FULL, z_ready low for 5 cycles
    bus.z_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", 32'(bus.x3_x0_ready), 32'b0000);
      tick();
      check("bp_zvalid", 32'(bus.z_valid), 32'd1);
      check("bp_zdata",  32'(bus.z_data), 32'hA3);
      check("bp_tag",    32'(bus.b1_b0), 32'd3);
      check("bp_ptr",    32'(dut.rr_ptr_q), 32'd0);
    end
    bus.z_ready = 1'b1;
    #1;
    check("rel_ready", 32'(bus.x3_x0_ready), 32'b0001);
    tick();
    check("rel_tag0",  32'(bus.b1_b0), 32'd0);
    check("rel_data0", 32'(bus.z_data), 32'hA0);
    tick();
    check("rel_zvalid", 32'(bus.z_valid), 32'd1);
    check("rel_tag1",   32'(bus.b1_b0), 32'd1);
    check("rel_data1",  32'(bus.z_data), 32'hA1);

    // Asynchronous reset while holding 0xFF
    bus.x3_x0_valid = 4'b0100;
    set_data(2, 8'hFF);
    tick();
    check("ar_full_data", 32'(bus.z_data), 32'hFF);
    bus.x3_x0_valid = 4'b0000;
    bus.z_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_zvalid", 32'(bus.z_valid), 32'd0);
    check("ar_zdata",  32'(bus.z_data), 32'h00);
    check("ar_tag",    32'(bus.b1_b0), 32'd0);
    bus.z_ready = 1'b1;
    #1;
    check("ar_ready", 32'(bus.x3_x0_ready), 32'b0000);
    reset = 1'b0;
    tick();
    check("ar_no_word", 32'(bus.z_valid), 32'd0);

    // Randomized traffic against a reference model and per-channel scoreboard
    mfull = 1'b0; mdata = '0; mtag = '0; mptr = '0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; exp_seq[i] = 0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.x3_x0_valid[i] && $urandom_range(0, 2) != 0) begin
          bus.x3_x0_valid[i] = 1'b1;
          set_data(i, {2'(i), 6'(seq[i])});
          seq[i]++;
        end
      end
      bus.z_ready = ($urandom_range(0, 3) != 0);
      #1;
      mg = (!mfull || bus.z_ready) ? rr_model(bus.x3_x0_valid, mptr) : 4'b0000;
      check("rnd_ready", 32'(bus.x3_x0_ready), 32'(mg));

      if (bus.z_valid && bus.z_ready) begin
        oc = int'(bus.b1_b0);
        check("sb_tag", 32'(bus.z_data[7:6]), 32'(bus.b1_b0));
        check("sb_order", 32'(bus.z_data[5:0]), 32'(exp_seq[oc] % 64));
        exp_seq[oc]++;
      end

      dg = bus.x3_x0_ready;
      if (dg != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (dg[i]) begin
            check("starve", 32'(waitc[i] <= 3), 32'd1);
            waitc[i] = 0;
          end else if (bus.x3_x0_valid[i]) begin
            waitc[i]++;
          end
        end
      end

      if (mg != 4'b0000) begin
        oc    = onehot_idx(mg);
        mfull = 1'b1;
        mdata = bus.x3_x0_data[oc*8 +: 8];
        mtag  = 2'(oc);
        mptr  = 2'(oc + 1);
      end else if (mfull && bus.z_ready) begin
        mfull = 1'b0;
      end

      tick();
      bus.x3_x0_valid = bus.x3_x0_valid & ~mg;
      check("rnd_zvalid", 32'(bus.z_valid), 32'(mfull));
      if (mfull) begin
        check("rnd_zdata", 32'(bus.z_data), 32'(mdata));
        check("rnd_tag",   32'(bus.b1_b0), 32'(mtag));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b4to1_rr_multiplexer.md
B4TO1_RR_MULTIPLEXER -- requirements
Module: b4to1_rr_multiplexer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width of each channel.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-004 The block SHALL have port x3_x0_valid, input, 4 bits, one valid flag per input channel.
REQ-005 The block SHALL have port x3_x0_data, input, 4*W bits, with channel i on bits [i*W+W-1 : i*W].
REQ-006 The block SHALL have port x3_x0_ready, output, 4 bits, one ready flag per input channel.
REQ-007 The block SHALL have port z_valid, output, 1 bit, asserted when the output register holds a word.
REQ-008 The block SHALL have port z_data, output, W bits, the held word.
REQ-009 The block SHALL have port b1_b0, output, 2 bits, the index of the channel the held word came from.
REQ-010 The block SHALL have port z_ready, input, 1 bit, the consumer's acceptance flag.

Function
REQ-011 A transfer on input i SHALL occur on a rising edge where x3_x0_valid[i] and x3_x0_ready[i] are both 1; an output transfer SHALL occur where z_valid and z_ready are both 1.
REQ-012 The block SHALL hold a one-entry output register with two states: EMPTY (z_valid=0) and FULL (z_valid=1).
REQ-013 slot_free SHALL be defined as (state==EMPTY) or (z_ready==1).
REQ-014 x3_x0_ready SHALL be combinational and one-hot-or-zero: only the granted channel is 1, and only when slot_free=1.
REQ-015 The grant SHALL go to the first channel with valid=1, searching from rr_ptr upward with modulo-4 wrap (rr_ptr, rr_ptr+1, ..., rr_ptr+3).
REQ-016 On an input transfer from channel g, the block SHALL load z_data from channel g, load b1_b0 with g, enter FULL, and set rr_ptr to (g+1) mod 4; the wrap from 3 goes to 0.
REQ-017 If the output transfers and no input transfers on the same edge, the block SHALL enter EMPTY and leave z_data and b1_b0 unchanged.
REQ-018 If the output transfers and an input transfers on the same edge, the block SHALL replace the held word and stay FULL; this gives one word per cycle with no bubble.
REQ-019 In FULL with z_ready=0, all x3_x0_ready SHALL be 0 and z_data, b1_b0 and rr_ptr SHALL be held stable.
REQ-020 Latency SHALL be exactly one cycle from input transfer to z_valid=1 carrying that word.
REQ-021 rr_ptr SHALL NOT change on cycles without an input transfer.
REQ-022 The block SHALL NOT drop or duplicate any word, and no channel holding valid=1 SHALL wait more than 3 grants to other channels.

Reset
REQ-023 While reset=1, regardless of clock, the block SHALL force state EMPTY, z_valid=0, z_data=0, b1_b0=0 and rr_ptr=0.
REQ-024 If reset asserts while FULL, the block SHALL discard the held word, and no output transfer SHALL be reported for it.
REQ-025 While reset=1, x3_x0_ready SHALL be 0000.

Structure
REQ-026 The following SHALL be in a shared include file: the state encoding constants S_EMPTY=1'b0 and S_FULL=1'b1, and the channel count 4.
REQ-027 The round-robin priority search SHALL be one sub-module, rr4_arbiter, which is purely combinational with inputs req[3:0] and ptr[1:0] and output gnt[3:0] (one-hot or zero).
REQ-028 The top level SHALL contain only the state, data and pointer registers, the rr4_arbiter instance, and the W-bit 4-to-1 data selection.

Verification
REQ-029 Scenario: after reset, x3_x0_valid=0100, channel 2 data=0x5A, z_ready=1 -> x3_x0_ready=0100; next cycle z_valid=1, z_data=0x5A, b1_b0=10, rr_ptr=3.
REQ-030 Scenario: x3_x0_valid=1111 held high, z_ready=1, 8 cycles -> b1_b0 sequence 00,01,10,11,00,01,10,11 with no bubble cycles.
REQ-031 Scenario: FULL with z_ready=0 for 5 cycles and x3_x0_valid=1111 -> x3_x0_ready=0000 and z_data/b1_b0 stable for all 5 cycles; releasing z_ready gives back-to-back transfers.
REQ-032 Scenario: rr_ptr=3, x3_x0_valid=1001 -> grant goes to channel 3; then rr_ptr=0 and the next grant goes to channel 0 (wrap check).
REQ-033 Scenario: reset pulsed mid-cycle, asynchronously, while FULL with z_data=0xFF -> z_valid=0 and z_data=0x00 immediately, before the next clock edge; the word is never seen transferred.
REQ-034 Scenario: random valid/ready over 10000 cycles with a scoreboard per channel -> all words delivered in per-channel order with the correct b1_b0 tag, and no channel starved beyond 3 grants.
